// File: rtl/sobel_pkg.sv
// Shared types, mode encodings and arithmetic helpers for the Sobel edge stage.
package sobel_pkg;

    localparam int PIX_W = 12;

    typedef logic [PIX_W-1:0] pix_t;

    typedef struct packed {
        pix_t r;
        pix_t g;
        pix_t b;
    } rgb_t;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_GRAY  = 2'd1,
        MODE_SOBEL = 2'd2,
        MODE_BIN   = 2'd3
    } mode_e;

    localparam pix_t MAG_SAT = 12'd4095;

    // Weighted luma (R + 2G + B) / 4; the 14-bit sum keeps the result exact.
    function automatic pix_t gray_of(input pix_t r, input pix_t g, input pix_t b);
        logic [PIX_W+1:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return sum[PIX_W+1:2];
    endfunction

    // One Sobel column/row tap: a + 2*c + b, at most 4 * 4095.
    function automatic logic [PIX_W+1:0] tap_sum(input pix_t a, input pix_t c, input pix_t b);
        return {2'b00, a} + {1'b0, c, 1'b0} + {2'b00, b};
    endfunction

endpackage

// File: rtl/sobel_edge_filter_if.sv
// Pixel-stream bundle between the Bayer converter (master) and the edge filter (slave).
interface sobel_edge_filter_if;
    import sobel_pkg::*;

    logic       iFVAL;
    logic       iDVAL;
    pix_t       iRed;
    pix_t       iGreen;
    pix_t       iBlue;
    logic [1:0] iMODE;
    pix_t       iTHRESH;
    pix_t       oRed;
    pix_t       oGreen;
    pix_t       oBlue;
    logic       oDVAL;

    modport master (
        output iFVAL, iDVAL, iRed, iGreen, iBlue, iMODE, iTHRESH,
        input  oRed, oGreen, oBlue, oDVAL
    );

    modport slave (
        input  iFVAL, iDVAL, iRed, iGreen, iBlue, iMODE, iTHRESH,
        output oRed, oGreen, oBlue, oDVAL
    );

endinterface

// File: rtl/line_buffer.sv
// Simple dual-port line memory with registered read; old data is returned on
// a same-address read/write so it maps onto M10K blocks.
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int W     = 12
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write port and registered read port; read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sobel_edge_filter.sv
// Streaming 3x3 Sobel edge stage: gray conversion, two line buffers, fixed
// 3-cycle latency in every mode so beat count and order are preserved.
module sobel_edge_filter
    import sobel_pkg::*;
#(
    parameter int WIDTH    = 640,
    parameter int ROW_BITS = 10
) (
    input  logic               iCLK,
    input  logic               iRST,
    sobel_edge_filter_if.slave bus
);

    localparam int COL_W = $clog2(WIDTH);

    // Stage 0 (combinational front end)
    logic                acc_s;
    logic                rise_s;
    mode_e               mode_s;
    pix_t                gray_s;
    rgb_t                rgb_in_s;
    logic                fval_d_r;
    mode_e               mode_r;
    logic [COL_W-1:0]    col_r;
    logic [ROW_BITS-1:0] row_r;

    // Stage 1
    logic             v1_r;
    pix_t             g1_r;
    rgb_t             rgb1_r;
    mode_e            m1_r;
    logic             bord1_r;
    logic [COL_W-1:0] col1_r;
    pix_t             lb1_rd_s;
    pix_t             lb2_rd_s;

    // Stage 2
    logic                         v2_r;
    pix_t                         g2_r;
    rgb_t                         rgb2_r;
    mode_e                        m2_r;
    logic                         bord2_r;
    logic [2:0][2:0][PIX_W-1:0]   win_r;
    logic [2:0][2:0][PIX_W-1:0]   win_s;
    logic signed [14:0]           gx_s;
    logic signed [14:0]           gy_s;
    logic signed [14:0]           gx2_r;
    logic signed [14:0]           gy2_r;

    // Stage 3
    logic [14:0] ax_s;
    logic [14:0] ay_s;
    logic [15:0] mag_s;
    pix_t        sat_s;
    pix_t        bin_s;
    rgb_t        out_s;
    rgb_t        out_r;
    logic        dval_r;

    // Beat acceptance, frame-start detection and gray conversion.
    always_comb begin
        acc_s    = bus.iDVAL && bus.iFVAL;
        rise_s   = bus.iFVAL && !fval_d_r;
        gray_s   = gray_of(bus.iRed, bus.iGreen, bus.iBlue);
        rgb_in_s = '{r: bus.iRed, g: bus.iGreen, b: bus.iBlue};
        if (rise_s) begin
            mode_s = mode_e'(bus.iMODE);
        end else begin
            mode_s = mode_r;
        end
    end

    // Frame-level control: mode latch on frame start, column/row position.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            fval_d_r <= 1'b0;
            mode_r   <= MODE_PASS;
            col_r    <= '0;
            row_r    <= '0;
            v1_r     <= 1'b0;
        end else begin
            fval_d_r <= bus.iFVAL;
            mode_r   <= mode_s;
            v1_r     <= acc_s;
            if (!bus.iFVAL) begin
                col_r <= '0;
                row_r <= '0;
            end else if (acc_s) begin
                if (col_r == COL_W'(WIDTH - 1)) begin
                    col_r <= '0;
                    if (row_r != '1) begin
                        row_r <= row_r + ROW_BITS'(1);
                    end
                end else begin
                    col_r <= col_r + COL_W'(1);
                end
            end
        end
    end

    // Stage-1 payload: the border flag is taken from the position at acceptance.
    always_ff @(posedge iCLK) begin
        if (acc_s) begin
            g1_r    <= gray_s;
            rgb1_r  <= rgb_in_s;
            m1_r    <= mode_s;
            bord1_r <= (row_r < ROW_BITS'(2)) || (col_r < COL_W'(2));
            col1_r  <= col_r;
        end
    end

    // line1 holds the previous row; it feeds line2 one stage later, which
    // still lands before that address is read again.
    line_buffer #(.DEPTH(WIDTH), .W(PIX_W)) u_line1 (
        .clk   (iCLK),
        .we    (acc_s),
        .waddr (col_r),
        .wdata (gray_s),
        .re    (acc_s),
        .raddr (col_r),
        .rdata (lb1_rd_s)
    );

    line_buffer #(.DEPTH(WIDTH), .W(PIX_W)) u_line2 (
        .clk   (iCLK),
        .we    (v1_r),
        .waddr (col1_r),
        .wdata (lb1_rd_s),
        .re    (acc_s),
        .raddr (col_r),
        .rdata (lb2_rd_s)
    );

    // Next window: shift left and insert the new column (oldest row on top).
    always_comb begin
        win_s = win_r;
        if (v1_r) begin
            for (int r = 0; r < 3; r++) begin
                win_s[r][0] = win_r[r][1];
                win_s[r][1] = win_r[r][2];
            end
            win_s[0][2] = lb2_rd_s;
            win_s[1][2] = lb1_rd_s;
            win_s[2][2] = g1_r;
        end else begin
            win_s = win_r;
        end
        gx_s = $signed({1'b0, tap_sum(win_s[0][2], win_s[1][2], win_s[2][2])})
             - $signed({1'b0, tap_sum(win_s[0][0], win_s[1][0], win_s[2][0])});
        gy_s = $signed({1'b0, tap_sum(win_s[2][0], win_s[2][1], win_s[2][2])})
             - $signed({1'b0, tap_sum(win_s[0][0], win_s[0][1], win_s[0][2])});
    end

    // Stage-2 valid.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            v2_r <= 1'b0;
        end else begin
            v2_r <= v1_r;
        end
    end

    // Stage-2 payload: window advances only on accepted beats.
    always_ff @(posedge iCLK) begin
        if (v1_r) begin
            win_r   <= win_s;
            gx2_r   <= gx_s;
            gy2_r   <= gy_s;
            g2_r    <= g1_r;
            rgb2_r  <= rgb1_r;
            m2_r    <= m1_r;
            bord2_r <= bord1_r;
        end
    end

    // Magnitude, saturation/threshold and per-beat mode selection.
    always_comb begin
        ax_s  = gx2_r[14] ? 15'(-gx2_r) : 15'(gx2_r);
        ay_s  = gy2_r[14] ? 15'(-gy2_r) : 15'(gy2_r);
        mag_s = {1'b0, ax_s} + {1'b0, ay_s};
        sat_s = (mag_s > 16'd4095) ? MAG_SAT : mag_s[11:0];
        bin_s = (mag_s >= {4'b0000, bus.iTHRESH}) ? MAG_SAT : 12'd0;
        case (m2_r)
            MODE_PASS:  out_s = rgb2_r;
            MODE_GRAY:  out_s = '{r: g2_r, g: g2_r, b: g2_r};
            MODE_SOBEL: out_s = bord2_r ? '0 : '{r: sat_s, g: sat_s, b: sat_s};
            MODE_BIN:   out_s = bord2_r ? '0 : '{r: bin_s, g: bin_s, b: bin_s};
            default:    out_s = '0;
        endcase
    end

    // Registered output stage.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            dval_r <= 1'b0;
            out_r  <= '0;
        end else begin
            dval_r <= v2_r;
            if (v2_r) begin
                out_r <= out_s;
            end
        end
    end

    assign bus.oRed   = out_r.r;
    assign bus.oGreen = out_r.g;
    assign bus.oBlue  = out_r.b;
    assign bus.oDVAL  = dval_r;

endmodule
